// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared definitions for the RC4 keystream decryptor.
//   dec_state_t        : FSM state encoding used by ram_decryptor
//   DEFAULT_RAM_WIDTH  : default S-box data/address width
//   DEFAULT_MSG_LENGTH : default number of message bytes per run
//   idx_width()        : width of a message-byte index (at least 1 bit)
`timescale 1ns/1ps
package rc4_pkg;

  localparam int DEFAULT_RAM_WIDTH  = 8;
  localparam int DEFAULT_MSG_LENGTH = 32;

  typedef enum logic [3:0] {
    IDLE,
    SET_I,
    WAIT_SI,
    READ_SI,
    WAIT_SJ,
    READ_SJ,
    WRITE_SI,
    WRITE_SJ,
    SET_F,
    WAIT_F,
    READ_F,
    WRITE_DEC,
    DONE
  } dec_state_t;

  // A one-byte message still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_decryptor_if.sv
// ram_decryptor_if -- controller/memory-side bundle of the RC4 decryptor.
//   start/finished                  : run handshake with the controller
//   ram_out/ram_in/address/
//   write_enable                    : S-box RAM port
//   rom_address/rom_data            : ciphertext ROM port
//   dec_address/dec_data/
//   dec_write_enable                : plaintext RAM write port
// Modports: master (controller + memories), slave (decryptor).
`timescale 1ns/1ps
interface ram_decryptor_if
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
  parameter int MSG_LENGTH = DEFAULT_MSG_LENGTH
) ();

  localparam int AW = idx_width(MSG_LENGTH);

  logic                 start;
  logic                 finished;
  logic [RAM_WIDTH-1:0] ram_out;
  logic                 write_enable;
  logic [RAM_WIDTH-1:0] ram_in;
  logic [RAM_WIDTH-1:0] address;
  logic [AW-1:0]        rom_address;
  logic [7:0]           rom_data;
  logic [AW-1:0]        dec_address;
  logic [7:0]           dec_data;
  logic                 dec_write_enable;

  modport master (
    output start, ram_out, rom_data,
    input  finished, write_enable, ram_in, address,
           rom_address, dec_address, dec_data, dec_write_enable
  );

  modport slave (
    input  start, ram_out, rom_data,
    output finished, write_enable, ram_in, address,
           rom_address, dec_address, dec_data, dec_write_enable
  );

endinterface

// File: rtl/ram_decryptor.sv
// ram_decryptor -- RC4 keystream generator / XOR decryptor over an S-box RAM
// that has already been initialised and shuffled with the key.
// For each message byte k: i=i+1, j=j+S[i], swap S[i]/S[j],
// f=S[S[i]+S[j]], dec[k]=rom[k]^f. Every byte takes 11 cycles.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; forces IDLE and clears all state
//   bus   : ram_decryptor_if.slave (start/finished, S-box RAM,
//           ciphertext ROM, plaintext RAM)
`timescale 1ns/1ps
module ram_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
  parameter int MSG_LENGTH = DEFAULT_MSG_LENGTH
) (
  input  logic           clk,
  input  logic           reset,
  ram_decryptor_if.slave bus
);

  localparam int                   AW     = idx_width(MSG_LENGTH);
  localparam logic [AW-1:0]        K_LAST = AW'(MSG_LENGTH - 1);
  localparam logic [AW-1:0]        K_ONE  = AW'(1);
  localparam logic [RAM_WIDTH-1:0] W_ONE  = RAM_WIDTH'(1);

  dec_state_t           state_q, state_d;
  logic [RAM_WIDTH-1:0] i_q, i_d;
  logic [RAM_WIDTH-1:0] j_q, j_d;
  logic [AW-1:0]        k_q, k_d;
  logic [RAM_WIDTH-1:0] si_q, si_d;
  logic [RAM_WIDTH-1:0] sj_q, sj_d;
  logic [RAM_WIDTH-1:0] f_q, f_d;
  logic [7:0]           rom_byte_q, rom_byte_d;

  // k is constant for the whole byte, so both memory indices simply follow it;
  // this also keeps the ROM read stable through READ_F.
  assign bus.rom_address = k_q;
  assign bus.dec_address = k_q;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    rom_byte_d = rom_byte_q;

    bus.finished         = 1'b0;
    bus.write_enable     = 1'b0;
    bus.ram_in           = '0;
    bus.address          = '0;
    bus.dec_data         = '0;
    bus.dec_write_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        if (bus.start) begin
          // i is advanced on the way into SET_I so the new i is already
          // on the address bus during SET_I.
          i_d     = W_ONE;
          state_d = SET_I;
        end
      end

      SET_I: begin
        bus.address = i_q;
        state_d     = WAIT_SI;
      end

      WAIT_SI: begin
        bus.address = i_q;
        state_d     = READ_SI;
      end

      READ_SI: begin
        bus.address = i_q;
        si_d        = bus.ram_out;
        j_d         = j_q + bus.ram_out;
        state_d     = WAIT_SJ;
      end

      WAIT_SJ: begin
        bus.address = j_q;
        state_d     = READ_SJ;
      end

      READ_SJ: begin
        bus.address = j_q;
        sj_d        = bus.ram_out;
        state_d     = WRITE_SI;
      end

      // When i==j both writes hit the same address with the same value,
      // so no special case is needed.
      WRITE_SI: begin
        bus.address      = i_q;
        bus.ram_in       = sj_q;
        bus.write_enable = 1'b1;
        state_d          = WRITE_SJ;
      end

      WRITE_SJ: begin
        bus.address      = j_q;
        bus.ram_in       = si_q;
        bus.write_enable = 1'b1;
        state_d          = SET_F;
      end

      SET_F: begin
        bus.address = si_q + sj_q;
        state_d     = WAIT_F;
      end

      WAIT_F: begin
        bus.address = si_q + sj_q;
        state_d     = READ_F;
      end

      READ_F: begin
        bus.address = si_q + sj_q;
        f_d         = bus.ram_out;
        rom_byte_d  = bus.rom_data;
        state_d     = WRITE_DEC;
      end

      WRITE_DEC: begin
        bus.dec_data         = rom_byte_q ^ 8'(f_q);
        bus.dec_write_enable = 1'b1;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + K_ONE;
          i_d     = i_q + W_ONE;
          state_d = SET_I;
        end
      end

      DONE: begin
        bus.finished = 1'b1;
        if (!bus.start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      f_q        <= '0;
      rom_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      rom_byte_q <= rom_byte_d;
    end
  end

endmodule

// File: doc/ram_decryptor.md
RAM_DECRYPTOR -- requirements
Module: ram_decryptor

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, giving the data and address width of every RAM/ROM port.
REQ-002 SHALL have parameter MSG_LENGTH, default 32, giving the number of message bytes processed per run (1..1024).
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  level request from the controller's start_bus slot.
REQ-007 finished  output  1  run complete, held until start low.
REQ-008 ram_out  input  RAM_WIDTH  S-box RAM read data.
REQ-009 write_enable  output  1  S-box RAM write strobe.
REQ-010 ram_in  output  RAM_WIDTH  S-box RAM write data.
REQ-011 address  output  RAM_WIDTH  S-box RAM address.
REQ-012 rom_address  output  clog2(MSG_LENGTH)  ciphertext ROM address.
REQ-013 rom_data  input  8  ciphertext ROM read data.
REQ-014 dec_address  output  clog2(MSG_LENGTH)  plaintext RAM address.
REQ-015 dec_data  output  8  plaintext RAM write data.
REQ-016 dec_write_enable  output  1  plaintext RAM write strobe.

Function
REQ-017 SHALL execute the RC4 keystream generator: i=j=0; for k in 0..MSG_LENGTH-1, the sequence is i=i+1, j=j+S[i], swap S[i]/S[j], f=S[S[i]+S[j]], dec[k]=rom[k] XOR f.
REQ-018 SHALL treat all RAMs/ROM as synchronous, with data valid in the second cycle after the cycle the address is first driven.
REQ-019 SHALL implement FSM states IDLE, SET_I, WAIT_SI, READ_SI, WAIT_SJ, READ_SJ, WRITE_SI, WRITE_SJ, SET_F, WAIT_F, READ_F, WRITE_DEC, DONE.
REQ-020 IDLE->SET_I when start=1; i,j,k cleared on entry to IDLE.
REQ-021 SET_I: i<=i+1, then address=new i and rom_address=k from SET_I through READ_SI.
REQ-022 READ_SI: latch si=ram_out and j<=j+si; address=new j from WAIT_SJ through READ_SJ; READ_SJ latches sj=ram_out.
REQ-023 WRITE_SI: address=i, ram_in=sj, write_enable=1; WRITE_SJ: address=j, ram_in=si, write_enable=1; write_enable=0 in all other states.
REQ-024 SET_F/WAIT_F: address=si+sj mod 2^RAM_WIDTH; READ_F latches f=ram_out and captures rom_data.
REQ-025 WRITE_DEC: dec_address=k, dec_data=rom byte XOR f, dec_write_enable=1 for exactly one cycle; then k<=k+1 and ->SET_I, or ->DONE if k==MSG_LENGTH-1.
REQ-026 Each byte SHALL take exactly 11 cycles; finished SHALL rise 11*MSG_LENGTH+1 edges after start is sampled high in IDLE.
REQ-027 DONE: finished=1 while start=1; start=0 ->IDLE with finished=0 the next cycle.
REQ-028 i, j and the f index SHALL wrap modulo 256 silently; i at byte k equals (k+1) mod 256.
REQ-029 i==j SHALL be handled without special casing: both writes carry the same value to the same address.
REQ-030 start deasserted mid-run SHALL be ignored; the run completes.
REQ-031 S-box contents SHALL remain the swapped permutation after the run.

Reset
REQ-032 reset SHALL force IDLE from any state, including mid-run, on the next edge.
REQ-033 reset SHALL clear i, j, k, si, sj and f to 0.
REQ-034 reset SHALL set every output (finished, write_enable, ram_in, address, rom_address, dec_address, dec_data, dec_write_enable) to 0.
REQ-035 No RAM write SHALL occur in the cycle after reset asserts.

Structure
REQ-036 SHALL place the state enum, default RAM_WIDTH and default MSG_LENGTH in shared package rc4_pkg.
REQ-037 SHALL be a single FSM module with no sub-module; it plugs into the controller as device index 2, mode 3'b011.

Verification
REQ-038 S[x]=x, rom all 0x00, MSG_LENGTH=2 -> dec[0]=0x02, dec[1]=0x05; S[2]=0x03, S[3]=0x02 after the run.
REQ-039 Byte 0 of the same run (i=j=1) -> two writes of 0x01 to address 0x01, with no other change to S.
REQ-040 MSG_LENGTH=257 -> SET_I of k=255 drives address 0x00; finished rises at edge 2828.
REQ-041 Assert reset during WRITE_SI of byte 3 -> next cycle IDLE, all outputs 0; a rerun from a re-initialised S matches the golden model.
REQ-042 Key 00 03 3C after ram_initializer/ram_shuffler, 32-byte ciphertext -> dec matches the software RC4 reference byte-for-byte; finished is held until start=0, then drops one cycle later.
